// File: rtl/exc_request_ctrl.sv
// Exception request initiator toward CP0: prioritises synchronous traps over synchronized
// interrupts, issues a one-cycle request, retries on decline and tracks handler residency.
module exc_request_ctrl #(
  parameter int N_IRQ       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             trap_ov,
  input  logic             trap_teq,
  input  logic             trap_syscall,
  input  logic             trap_break,
  input  logic             status_ie,
  input  logic             mtc0,
  input  logic             eret,
  input  logic             ans_exception,
  output logic             exception,
  output logic [4:0]       cause,
  output logic             stall,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             trap_dropped
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HANDLER} state_t;

  state_t                                state, next_state;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0]     sync_q;
  logic                                  trap_pend;
  logic [4:0]                            pend_cause;
  logic                                  trap_any;
  logic [4:0]                            trap_code;
  logic                                  cand_valid;
  logic [4:0]                            cand_cause;

  // Interrupt lines are asynchronous; only the last synchronizer stage is trusted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    // NOTE: every clocked block uses non-blocking assignments so that all registers
    // update from the same pre-edge values, independent of statement order.
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
  end

  assign irq_pending = sync_q[SYNC_STAGES-1] & irq_mask;
  assign trap_any    = trap_ov | trap_teq | trap_syscall | trap_break;

  always_comb begin
    // NOTE: a default assignment ahead of the priority chain keeps this block latch-free.
    trap_code = 5'd0;
    if      (trap_ov)      trap_code = 5'd12;
    else if (trap_teq)     trap_code = 5'd13;
    else if (trap_syscall) trap_code = 5'd8;
    else if (trap_break)   trap_code = 5'd9;
  end

  assign cand_valid = trap_pend | (|irq_pending);
  assign cand_cause = trap_pend ? pend_cause : 5'd0;

  // A trap is held until CP0 accepts it; a trap arriving while one is held (or with
  // interrupts globally disabled) is lost and flagged until the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_pend    <= 1'b0;
      pend_cause   <= 5'd0;
      trap_dropped <= 1'b0;
    end else begin
      if (state == WAIT && ans_exception && cause != 5'd0) trap_pend <= 1'b0;
      if (trap_any) begin
        if (!trap_pend && status_ie) begin
          trap_pend  <= 1'b1;
          pend_cause <= trap_code;
        end else begin
          trap_dropped <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cand_valid && status_ie && !mtc0) next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT:    next_state = ans_exception ? HANDLER : IDLE;
      HANDLER: if (eret) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = trap_pend | (state == REQ) | (state == WAIT);
  end

  // The request strobe is registered so CP0 sees a clean one-cycle pulse; cause is kept
  // after the strobe so the WAIT decision knows whether a trap was being served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exception <= 1'b0;
      cause     <= 5'd0;
    end else begin
      exception <= (state == IDLE) && (next_state == REQ);
      if (state == IDLE && next_state == REQ) cause <= cand_cause;
    end
  end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Directed bench for exc_request_ctrl: a transaction-level model is compared every cycle,
// and literal expectations at key cycles pin the model.
module tb_exc_request_ctrl;
  localparam int N_IRQ = 6;
  localparam int SS    = 2;

  logic             clk;
  logic             reset;
  logic [N_IRQ-1:0] irq, irq_mask;
  logic             trap_ov, trap_teq, trap_syscall, trap_break;
  logic             status_ie, mtc0, eret, ans_exception;
  logic             exception;
  logic [4:0]       cause;
  logic             stall;
  logic [N_IRQ-1:0] irq_pending;
  logic             trap_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  exc_request_ctrl #(.N_IRQ(N_IRQ), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask),
    .trap_ov(trap_ov), .trap_teq(trap_teq), .trap_syscall(trap_syscall), .trap_break(trap_break),
    .status_ie(status_ie), .mtc0(mtc0), .eret(eret), .ans_exception(ans_exception),
    .exception(exception), .cause(cause), .stall(stall),
    .irq_pending(irq_pending), .trap_dropped(trap_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state in terms of the handshake: pending trap, request in flight, handler residency.
  bit               m_pend    = 0;
  bit               m_strobe  = 0;
  bit               m_await   = 0;
  bit               m_handler = 0;
  bit               m_dropped = 0;
  logic [4:0]       m_pcause  = '0;
  logic [4:0]       m_cause   = '0;
  logic [N_IRQ-1:0] m_line [SS];

  task automatic model_reset();
    m_pend = 0; m_strobe = 0; m_await = 0; m_handler = 0; m_dropped = 0;
    m_pcause = '0; m_cause = '0;
    for (int i = 0; i < SS; i++) m_line[i] = '0;
  endtask

  task automatic model_step();
    bit               old_pend;
    logic [N_IRQ-1:0] seen;
    old_pend = m_pend;
    seen     = m_line[SS-1] & irq_mask;
    if (m_strobe) begin
      m_strobe = 0;
      m_await  = 1;
    end else if (m_await) begin
      m_await = 0;
      if (ans_exception) begin
        m_handler = 1;
        if (m_cause != 5'd0) m_pend = 0;
      end
    end else if (m_handler) begin
      if (eret) m_handler = 0;
    end else if ((old_pend || seen != '0) && status_ie && !mtc0) begin
      m_strobe = 1;
      m_cause  = old_pend ? m_pcause : 5'd0;
    end
    if (trap_ov || trap_teq || trap_syscall || trap_break) begin
      if (!old_pend && status_ie) begin
        m_pend   = 1;
        m_pcause = trap_ov ? 5'd12 : trap_teq ? 5'd13 : trap_syscall ? 5'd8 : 5'd9;
      end else begin
        m_dropped = 1;
      end
    end
    for (int i = SS - 1; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0] = irq;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("cyc_exception", exception, m_strobe);
        check("cyc_stall", stall, m_pend | m_strobe | m_await);
        check("cyc_irq_pending", irq_pending, m_line[SS-1] & irq_mask);
        check("cyc_trap_dropped", trap_dropped, m_dropped);
        if (m_strobe) check("cyc_cause", cause, m_cause);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    irq = '0; irq_mask = '0;
    trap_ov = 0; trap_teq = 0; trap_syscall = 0; trap_break = 0;
    status_ie = 1; mtc0 = 0; eret = 0; ans_exception = 0;
    #12;
    check("rst_exception", exception, 0);
    check("rst_cause", cause, 0);
    check("rst_stall", stall, 0);
    check("rst_dropped", trap_dropped, 0);
    check("rst_irq_pending", irq_pending, 0);
    reset = 1'b1;
    repeat (2) tick();

    // syscall: request two cycles after the pulse, stall across t1..t3
    trap_syscall = 1;
    check("sc_stall_t0", stall, 0);
    tick(); trap_syscall = 0;
    check("sc_stall_t1", stall, 1);
    check("sc_exc_t1", exception, 0);
    tick();
    check("sc_exc_t2", exception, 1);
    check("sc_cause_t2", cause, 8);
    check("sc_stall_t2", stall, 1);
    tick(); ans_exception = 1;
    check("sc_exc_t3", exception, 0);
    check("sc_stall_t3", stall, 1);
    tick(); ans_exception = 0;
    check("sc_stall_t4", stall, 0);
    eret = 1;
    tick(); eret = 0;
    repeat (2) tick();

    // ov and break together: single request with cause 12, nothing flagged
    trap_ov = 1; trap_break = 1;
    tick(); trap_ov = 0; trap_break = 0;
    tick();
    check("ovbrk_exc", exception, 1);
    check("ovbrk_cause", cause, 12);
    tick(); ans_exception = 1;
    tick(); ans_exception = 0;
    check("ovbrk_dropped", trap_dropped, 0);
    eret = 1;
    tick(); eret = 0;
    repeat (3) tick();
    check("ovbrk_no_second", exception, 0);

    // masked interrupt line 2
    irq_mask = 6'b000100; irq = 6'b000100;
    check("irq_pend_t0", irq_pending, 0);
    tick();
    check("irq_pend_t1", irq_pending, 0);
    tick();
    check("irq_pend_t2", irq_pending, 6'b000100);
    check("irq_stall_t2", stall, 0);
    check("irq_exc_t2", exception, 0);
    tick();
    check("irq_exc_t3", exception, 1);
    check("irq_cause_t3", cause, 0);
    tick(); ans_exception = 1;
    tick(); ans_exception = 0; irq = '0;
    check("irq_stall_hdl", stall, 0);
    repeat (3) tick();
    check("irq_pend_cleared", irq_pending, 0);
    eret = 1;
    tick(); eret = 0;
    tick();

    // teq declined because mtc0 collided with the request, then retried
    trap_teq = 1;
    tick(); trap_teq = 0;
    tick();
    check("mtc_exc_first", exception, 1);
    check("mtc_cause_first", cause, 13);
    mtc0 = 1;
    tick(); mtc0 = 0; ans_exception = 0;
    check("mtc_exc_wait", exception, 0);
    tick();
    check("mtc_stall_idle", stall, 1);
    check("mtc_exc_idle", exception, 0);
    tick();
    check("mtc_exc_retry", exception, 1);
    check("mtc_cause_retry", cause, 13);
    tick(); ans_exception = 1;
    tick(); ans_exception = 0;
    check("mtc_stall_hdl", stall, 0);

    // trap in handler with IE=0 is dropped
    status_ie = 0; trap_teq = 1;
    tick(); trap_teq = 0;
    check("ie0_dropped", trap_dropped, 1);
    check("ie0_stall", stall, 0);
    eret = 1;
    tick(); eret = 0; status_ie = 1;
    repeat (3) tick();
    check("ie0_no_req", exception, 0);
    check("ie0_idle_stall", stall, 0);

    // interrupt held while IE=0, taken once IE returns
    status_ie = 0; irq = 6'b000100;
    repeat (4) tick();
    check("irqie0_exc", exception, 0);
    check("irqie0_pend", irq_pending, 6'b000100);
    status_ie = 1;
    tick();
    check("irqie1_exc", exception, 1);
    check("irqie1_cause", cause, 0);
    tick(); ans_exception = 1;
    tick(); ans_exception = 0; irq = '0;
    repeat (3) tick();
    eret = 1;
    tick(); eret = 0;
    tick();

    // asynchronous reset while waiting for CP0's answer
    trap_ov = 1;
    tick(); trap_ov = 0;
    tick();
    tick();
    check("rstw_stall_before", stall, 1);
    check("rstw_dropped_before", trap_dropped, 1);
    reset = 1'b0;
    #1;
    check("rstw_exception", exception, 0);
    check("rstw_stall", stall, 0);
    check("rstw_dropped", trap_dropped, 0);
    tick(); reset = 1'b1;
    tick();
    check("rstw_stall_after", stall, 0);
    check("rstw_exc_after", exception, 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
